decade_chain_ctrl: RTL and testbench
====================================

Name: decade_chain_ctrl

Overview:
- Sequencer for a cascade of DIGITS decade (0-9) BCD counter stages, forming a multi-digit BCD stopwatch/event counter.
- Owns a clock prescaler, a run/pause/idle state machine, preset loading and digit-to-digit carry sequencing.
- Drives the packed BCD value and status to display or compare logic downstream.

Parameters:
DIGITS, 4, number of cascaded decade stages (1..8); digit 0 is least significant, occupying bcd_out[3:0].
PRESCALE, 10, clk cycles per count tick (>=1); prescaler width = clog2(PRESCALE), minimum 1 bit.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  level; run or resume counting
stop  input  1  level; pause counting
clear  input  1  level; zero all digits, return to IDLE
load  input  1  level; preset digits from load_val
load_val  input  4*DIGITS  preset value, packed BCD
bcd_out  output  4*DIGITS  current count, packed BCD, registered
running  output  1  high while in RUN
tick  output  1  one-cycle pulse on each cycle the count advances
ovf  output  1  one-cycle pulse when count wraps from all-9s to all-0s

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state=IDLE; bcd_out=0; prescaler=0; running=0; tick=0; ovf=0.
- States: IDLE (count held; zero after reset/clear), RUN, PAUSE.
- Command priority, evaluated each cycle: clear > load > stop > start.
- clear: from any state, next cycle has state=IDLE, bcd_out=0, prescaler=0.
- load: honoured only in IDLE or PAUSE; ignored in RUN.
  - bcd_out <= load_val at the next edge; state unchanged; prescaler=0.
  - Any load_val nibble >9 is loaded as 0, per digit.
- IDLE: start -> RUN.
- RUN: stop -> PAUSE; start and stop together -> PAUSE.
- PAUSE: start (stop low) -> RUN. Prescaler value is held while in PAUSE, so the partial period resumes where it stopped.
- Prescaler:
  - Counts only in RUN, 0..PRESCALE-1.
  - On the cycle it equals PRESCALE-1 and the state is RUN (no stop/clear): it wraps to 0 and the count advances at that same edge.
  - tick is registered and high for exactly the cycle after the advancing edge, aligned with the new bcd_out.
  - PRESCALE=1: advances every RUN cycle.
- Advance:
  - Digit 0 increments. Any digit at 9 becomes 0 and carries into the next digit in the same edge (full ripple resolved combinationally, single-cycle update).
  - Digits never hold values >9.
- Wrap: all digits 9 plus advance -> all 0, ovf pulses with tick in the same cycle, state remains RUN.
- stop, clear or load arriving on a prescaler terminal cycle wins; the count does not advance that cycle.
- running = (state==RUN), registered.
- rst mid-operation overrides everything at the next edge.

Optional Feature:
Macro LAP_CAPTURE_EN.
- Defined: adds ports lap (input 1) and lap_val (output 4*DIGITS, reset 0).
  - lap high in RUN or PAUSE: lap_val <= bcd_out value presented in that same cycle, i.e. pre-advance.
  - clear zeroes lap_val.
  - lap ignored in IDLE.
- Undefined: ports and register absent; all other behaviour identical.

Test Plan:
- DIGITS=4, PRESCALE=3; rst, then start held 1 cycle.
  -> running=1 next cycle; bcd_out steps 0000,0001,0002 every 3 clks; tick high 1 cycle per step.
- load 0x0998 in IDLE, start, run 2 ticks.
  -> bcd_out 0999 then 1000 (three-digit ripple in one edge); ovf stays 0.
- load 0x9999, start, 1 tick.
  -> bcd_out=0000, tick=1 and ovf=1 in the same cycle, running stays 1.
- RUN at prescaler=1, stop for 5 cycles, then start.
  -> bcd_out frozen during PAUSE; next advance occurs 2 clks after RUN resumes.
- load_val=0x00A5 in PAUSE -> bcd_out=0005. Then assert load in RUN -> bcd_out unaffected.
- start+stop together in RUN -> PAUSE. clear and load together -> bcd_out=0000, IDLE. With LAP_CAPTURE_EN: lap at 0042 -> lap_val=0042, held while count advances.

Source files
------------

// File: rtl/decade_chain_ctrl_if.sv
// Command/status bundle for decade_chain_ctrl.
// Optional lap capture signals exist only when LAP_CAPTURE_EN is defined.
interface decade_chain_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  running;
    logic                  tick;
    logic                  ovf;
`ifdef LAP_CAPTURE_EN
    logic                  lap;
    logic [4*DIGITS-1:0]   lap_val;

    modport master (
        output start, stop, clear, load, load_val, lap,
        input  bcd_out, running, tick, ovf, lap_val
    );
    modport slave (
        input  start, stop, clear, load, load_val, lap,
        output bcd_out, running, tick, ovf, lap_val
    );
`else
    modport master (
        output start, stop, clear, load, load_val,
        input  bcd_out, running, tick, ovf
    );
    modport slave (
        input  start, stop, clear, load, load_val,
        output bcd_out, running, tick, ovf
    );
`endif
endinterface

// File: rtl/decade_chain_ctrl.sv
// Multi-digit BCD stopwatch/event-counter sequencer: prescaler, IDLE/RUN/PAUSE
// control, preset loading and single-cycle ripple carry across DIGITS decades.
// Optional feature macro: LAP_CAPTURE_EN (adds lap / lap_val snapshot register).
// A load seen while running is not honoured, but like stop it still claims the
// cycle: the prescaler holds and the count does not advance on that cycle.
module decade_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rst,
    decade_chain_ctrl_if.slave  bus
);
    localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);
    localparam int            W     = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t         state, state_next;
    logic [PW-1:0]  presc, presc_next;
    logic [W-1:0]   bcd, bcd_next;
    logic [W-1:0]   bcd_inc, load_clean;
    logic           all_nines;
    logic           counting, adv, load_ok;
    logic           running_q, tick_q, ovf_q;
    logic           running_d, tick_d, ovf_d;

    assign load_ok  = bus.load && (state != RUN);
    // stop, clear or a load arriving during RUN all suppress counting this cycle
    assign counting = (state == RUN) && !bus.clear && !bus.load && !bus.stop;
    assign adv      = counting && (presc == PTERM);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode with priority clear > load > stop > start
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (!load_ok) begin
            unique case (state)
                IDLE:    if (bus.start && !bus.stop) state_next = RUN;
                RUN:     if (bus.stop)               state_next = PAUSE;
                PAUSE:   if (bus.start && !bus.stop) state_next = RUN;
                default:                             state_next = IDLE;
            endcase
        end
    end

    // Ripple-carry increment of all digits and per-digit sanitising of the preset
    always_comb begin : advance_logic
        logic carry;
        logic [3:0] d;
        carry      = 1'b1;
        bcd_inc    = bcd;
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = bcd[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = d + 4'd1;
                    carry             = 1'b0;
                end
            end
            load_clean[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
        end
        all_nines = carry;
    end

    // Next count and prescaler values
    always_comb begin
        bcd_next   = bcd;
        presc_next = presc;
        if (bus.clear) begin
            bcd_next   = '0;
            presc_next = '0;
        end else if (load_ok) begin
            bcd_next   = load_clean;
            presc_next = '0;
        end else if (counting) begin
            presc_next = adv ? '0 : presc + PW'(1);
            if (adv) bcd_next = bcd_inc;
        end
    end

    // Output decode feeding the registered status flags
    always_comb begin
        running_d = (state_next == RUN);
        tick_d    = adv;
        ovf_d     = adv && all_nines;
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd       <= '0;
            presc     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            bcd       <= bcd_next;
            presc     <= presc_next;
            running_q <= running_d;
            tick_q    <= tick_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.bcd_out = bcd;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
    assign bus.ovf     = ovf_q;

`ifdef LAP_CAPTURE_EN
    logic [W-1:0] lap_q;

    // Lap snapshot of the pre-advance count while RUN or PAUSE
    always_ff @(posedge clk) begin
        if (rst)                                        lap_q <= '0;
        else if (bus.clear)                             lap_q <= '0;
        else if (bus.lap && (state != IDLE))            lap_q <= bcd;
    end

    assign bus.lap_val = lap_q;
`endif

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Self-checking bench for decade_chain_ctrl (DIGITS=4, PRESCALE=3): a vector
// table, directed corner sequences and a randomized run against an
// integer-count reference model.
module tb_decade_chain_ctrl;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 3;
    localparam int MAXC     = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decade_chain_ctrl_if #(.DIGITS(DIGITS)) bus();

    decade_chain_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_count = 0;
    int      m_phase = 0;
    bit      m_tick  = 0;
    bit      m_ovf   = 0;
    int      m_lap   = 0;

    typedef struct {
        logic        start, stop, clear, load;
        logic [15:0] load_val;
        logic [15:0] exp_bcd;
        logic        exp_running, exp_tick, exp_ovf;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int value, pw, nib;
        value = 0;
        pw    = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib   = int'(lv[4*i +: 4]);
            value += ((nib > 9) ? 0 : nib) * pw;
            pw    *= 10;
        end
        return value;
    endfunction

    function automatic bit lap_in();
`ifdef LAP_CAPTURE_EN
        return bus.lap;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: one clock edge of the specified behaviour on integer state.
    task automatic model_step();
        mstate_t s0  = m_state;
        int      c0  = m_count;
        bit      adv = 0;
        if (rst) begin
            m_state = M_IDLE; m_count = 0; m_phase = 0;
            m_tick = 0; m_ovf = 0; m_lap = 0;
            return;
        end
        if (bus.clear) begin
            m_state = M_IDLE; m_count = 0; m_phase = 0;
        end else if (bus.load && s0 != M_RUN) begin
            m_count = load_to_int(bus.load_val);
            m_phase = 0;
        end else begin
            if (s0 == M_RUN && !bus.stop && !bus.load) begin
                if (m_phase == PRESCALE - 1) begin
                    adv = 1; m_phase = 0; m_count = (c0 + 1) % MAXC;
                end else begin
                    m_phase++;
                end
            end
            case (s0)
                M_IDLE:  if (bus.start && !bus.stop) m_state = M_RUN;
                M_RUN:   if (bus.stop)               m_state = M_PAUSE;
                M_PAUSE: if (bus.start && !bus.stop) m_state = M_RUN;
                default: m_state = M_IDLE;
            endcase
        end
        m_tick = adv;
        m_ovf  = adv && (c0 == MAXC - 1);
        if (bus.clear)                     m_lap = 0;
        else if (lap_in() && s0 != M_IDLE) m_lap = c0;
    endtask

    task automatic compare_model();
        check("model_bcd",     bus.bcd_out, to_bcd(m_count));
        check("model_running", bus.running, m_state == M_RUN);
        check("model_tick",    bus.tick,    m_tick);
        check("model_ovf",     bus.ovf,     m_ovf);
`ifdef LAP_CAPTURE_EN
        check("model_lap_val", bus.lap_val, to_bcd(m_lap));
`endif
    endtask

    task automatic set_in(input logic s, input logic p, input logic c, input logic l,
                          input logic [15:0] lv = 16'h0, input logic lp = 1'b0);
        bus.start = s; bus.stop = p; bus.clear = c; bus.load = l; bus.load_val = lv;
`ifdef LAP_CAPTURE_EN
        bus.lap = lp;
`else
        if (lp) begin end
`endif
    endtask

    // One clock: advance the model at the edge, then compare #1 later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic run_until_tick(input int budget, input logic [15:0] exp_bcd,
                                  input logic exp_ovf, input string name);
        bit seen = 0;
        set_in(0, 0, 0, 0);
        for (int n = 0; n < budget && !seen; n++) begin
            cycle();
            if (bus.tick) begin
                seen = 1;
                check({name, "_bcd"}, bus.bcd_out, exp_bcd);
                check({name, "_ovf"}, bus.ovf, exp_ovf);
            end
        end
        check({name, "_tick_seen"}, seen, 1);
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 16'h0, 16'h0000, 1, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 16'h0, 16'h0000, 1, 0, 0};
        vecs[2] = '{0, 0, 0, 0, 16'h0, 16'h0000, 1, 0, 0};
        vecs[3] = '{0, 0, 0, 0, 16'h0, 16'h0001, 1, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 16'h0, 16'h0001, 1, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 16'h0, 16'h0002, 1, 1, 0};

        set_in(0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_bcd",     bus.bcd_out, 16'h0000);
        check("reset_running", bus.running, 1'b0);
        check("reset_tick",    bus.tick,    1'b0);
        check("reset_ovf",     bus.ovf,     1'b0);

        // Start held one cycle, then count steps every PRESCALE clocks.
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].load, vecs[i].load_val);
            cycle();
            check($sformatf("vec%0d_bcd", i),     bus.bcd_out, vecs[i].exp_bcd);
            check($sformatf("vec%0d_running", i), bus.running, vecs[i].exp_running);
            check($sformatf("vec%0d_tick", i),    bus.tick,    vecs[i].exp_tick);
            check($sformatf("vec%0d_ovf", i),     bus.ovf,     vecs[i].exp_ovf);
        end

        // Three-digit ripple from 0998.
        set_in(0, 0, 1, 0); cycle();
        set_in(0, 0, 0, 1, 16'h0998); cycle();
        check("ripple_load", bus.bcd_out, 16'h0998);
        set_in(1, 0, 0, 0); cycle();
        check("ripple_running", bus.running, 1'b1);
        run_until_tick(10, 16'h0999, 1'b0, "ripple1");
        run_until_tick(10, 16'h1000, 1'b0, "ripple2");

        // Wrap from 9999.
        set_in(0, 0, 1, 0); cycle();
        set_in(0, 0, 0, 1, 16'h9999); cycle();
        set_in(1, 0, 0, 0); cycle();
        run_until_tick(10, 16'h0000, 1'b1, "wrap");
        check("wrap_running", bus.running, 1'b1);

        // Pause at prescaler=1 preserves the partial period.
        set_in(0, 0, 1, 0); cycle();
        set_in(1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0); cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, 0); cycle();
            check($sformatf("pause%0d_bcd", i), bus.bcd_out, 16'h0000);
            check($sformatf("pause%0d_running", i), bus.running, 1'b0);
        end
        set_in(1, 0, 0, 0); cycle();
        check("resume_running", bus.running, 1'b1);
        set_in(0, 0, 0, 0); cycle();
        check("resume_first_tick", bus.tick, 1'b0);
        cycle();
        check("resume_second_tick", bus.tick, 1'b1);
        check("resume_bcd", bus.bcd_out, 16'h0001);

        // Load in PAUSE sanitises nibbles; load in RUN is ignored.
        set_in(0, 1, 0, 0); cycle();
        set_in(0, 0, 0, 1, 16'h00A5); cycle();
        check("pause_load_bcd", bus.bcd_out, 16'h0005);
        check("pause_load_running", bus.running, 1'b0);
        set_in(1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 16'h1234); cycle();
        check("run_load_bcd", bus.bcd_out, 16'h0005);
        check("run_load_running", bus.running, 1'b1);

        // start+stop in RUN pauses; clear beats load.
        set_in(1, 1, 0, 0); cycle();
        check("startstop_running", bus.running, 1'b0);
        set_in(0, 0, 1, 1, 16'h4321); cycle();
        check("clearload_bcd", bus.bcd_out, 16'h0000);
        check("clearload_running", bus.running, 1'b0);

`ifdef LAP_CAPTURE_EN
        // Lap snapshot held while the count advances.
        set_in(0, 0, 0, 1, 16'h0042); cycle();
        set_in(1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 16'h0, 1'b1); cycle();
        check("lap_capture", bus.lap_val, 16'h0042);
        run_until_tick(10, 16'h0043, 1'b0, "lap_advance");
        check("lap_held", bus.lap_val, 16'h0042);
`endif

        // Randomized run against the model, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h9998 : 16'h9999)
                                            : 16'($urandom);
            set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                   $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 5,
                   lv, $urandom_range(0, 99) < 10);
            rst = (i == 1500);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
